// File: rtl/uart_xmit_fifo.sv
// Buffered 8N1 UART transmitter: a small FIFO feeds a start/data/stop serializer, LSB first.
// Optional even-parity bit between data and stop when UART_PARITY_EN is defined.
module uart_xmit_fifo #(
    parameter int BIT_CELL   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_l,
    input  logic               wr_validH,
    input  logic [7:0]         wr_dataH,
    output logic               wr_readyH,
    output logic               uart_xmitH,
    output logic               xmit_busyH,
    output logic               xmit_doneH,
    output logic [FIFO_AW:0]   fifo_countH
);
    localparam int CW = $clog2(BIT_CELL);
    localparam logic [CW-1:0]    CNT_LAST = CW'(BIT_CELL - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [7:0]         fifo_mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]   count_r, count_nxt_s;
    state_t             state_r, state_nxt_s;
    logic [CW-1:0]      bit_cnt_r, bit_cnt_nxt_s;
    logic [2:0]         bit_idx_r, bit_idx_nxt_s;
    logic [7:0]         shift_r, shift_nxt_s;
    logic               xmit_r, xmit_nxt_s;
    logic               done_r, done_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               push_s, pop_s, cell_end_s;
    logic [7:0]         head_s;
`ifdef UART_PARITY_EN
    logic               parity_r, parity_nxt_s;
`endif

    assign wr_readyH   = (count_r != FULL_CNT);
    assign push_s      = wr_validH && wr_readyH;
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign uart_xmitH  = xmit_r;
    assign xmit_busyH  = busy_r;
    assign xmit_doneH  = done_r;
    assign fifo_countH = count_r;

    // Serializer next-state: bit timing, shifting and FIFO pop requests.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        xmit_nxt_s    = xmit_r;
        pop_s         = 1'b0;
        cell_end_s    = (bit_cnt_r == CNT_LAST);
`ifdef UART_PARITY_EN
        parity_nxt_s  = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                xmit_nxt_s    = 1'b1;
                bit_cnt_nxt_s = '0;
                bit_idx_nxt_s = 3'd0;
                if (count_r != '0) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = head_s;
                    state_nxt_s = ST_START;
                    xmit_nxt_s  = 1'b0;
`ifdef UART_PARITY_EN
                    parity_nxt_s = even_parity(head_s);
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cell_end_s) begin
                    state_nxt_s   = ST_DATA;
                    bit_cnt_nxt_s = '0;
                    bit_idx_nxt_s = 3'd0;
                    xmit_nxt_s    = shift_r[0];
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (cell_end_s) begin
                    bit_cnt_nxt_s = '0;
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_nxt_s = ST_PARITY;
                        xmit_nxt_s  = parity_r;
`else
                        state_nxt_s = ST_STOP;
                        xmit_nxt_s  = 1'b1;
`endif
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 1'b1;
                        shift_nxt_s   = {1'b0, shift_r[7:1]};
                        xmit_nxt_s    = shift_r[1];
                    end
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (cell_end_s) begin
                    state_nxt_s   = ST_STOP;
                    bit_cnt_nxt_s = '0;
                    xmit_nxt_s    = 1'b1;
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cell_end_s) begin
                    bit_cnt_nxt_s = '0;
                    bit_idx_nxt_s = 3'd0;
                    // Chain straight into the next start bit so frames stay back-to-back.
                    if (count_r != '0) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = head_s;
                        state_nxt_s = ST_START;
                        xmit_nxt_s  = 1'b0;
`ifdef UART_PARITY_EN
                        parity_nxt_s = even_parity(head_s);
`endif
                    end else begin
                        state_nxt_s = ST_IDLE;
                        xmit_nxt_s  = 1'b1;
                    end
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                bit_cnt_nxt_s = '0;
                bit_idx_nxt_s = 3'd0;
                xmit_nxt_s    = 1'b1;
            end
        endcase
        // Registered done lands on the final stop cycle itself.
        done_nxt_s = (state_nxt_s == ST_STOP) && (bit_cnt_nxt_s == CNT_LAST);
    end

    // FIFO occupancy and busy lookahead.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 1'b1;
            2'b01:   count_nxt_s = count_r - 1'b1;
            default: count_nxt_s = count_r;
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE) || (count_nxt_s != '0);
    end

    // FIFO storage and pointers.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= 8'h00;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= wr_dataH;
                wr_ptr_r             <= wr_ptr_r + 1'b1;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
            count_r <= count_nxt_s;
        end
    end

    // Serializer state and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            xmit_r    <= 1'b1;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
`ifdef UART_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            xmit_r    <= xmit_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= busy_nxt_s;
`ifdef UART_PARITY_EN
            parity_r  <= parity_nxt_s;
`endif
        end
    end
endmodule

// File: tb/tb_uart_xmit_fifo.sv
// Directed bench for uart_xmit_fifo: vector table for FIFO fill/overflow, hand sequences for
// frame timing, back-to-back frames, push-during-pop and asynchronous reset mid-frame.
module tb_uart_xmit_fifo;
    localparam int BC = 16;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_l;
    logic       wr_validH;
    logic [7:0] wr_dataH;
    logic       wr_readyH, uart_xmitH, xmit_busyH, xmit_doneH;
    logic [2:0] fifo_countH;

    uart_xmit_fifo #(.BIT_CELL(BC), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .wr_validH(wr_validH), .wr_dataH(wr_dataH),
        .wr_readyH(wr_readyH), .uart_xmitH(uart_xmitH), .xmit_busyH(xmit_busyH),
        .xmit_doneH(xmit_doneH), .fifo_countH(fifo_countH)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    int         done_q[$];
    int         mon_err = 0;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        int         exp_count;
        logic       exp_ready;
        logic       exp_line;
    } vec_t;

    // Line monitor: mid-cell sampling receiver plus done-pulse timestamps.
    initial begin
        bit         act = 1'b0;
        int         cnt = 0;
        int         idx;
        logic [7:0] sh = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_l !== 1'b1) begin
                act = 1'b0;
                cnt = 0;
            end else begin
                if (xmit_doneH === 1'b1) done_q.push_back(cyc);
                if (!act) begin
                    if (uart_xmitH === 1'b0) begin
                        act = 1'b1;
                        cnt = 0;
                    end
                end else begin
                    cnt++;
                    if (cnt % BC == BC / 2) begin
                        idx = cnt / BC;
                        if (idx == 0) begin
                            if (uart_xmitH !== 1'b0) mon_err++;
                        end else if (idx <= 8) begin
                            sh = {uart_xmitH, sh[7:1]};
                        end else if (idx == FB - 1) begin
                            if (uart_xmitH !== 1'b1) mon_err++;
                            rx_q.push_back(sh);
                            act = 1'b0;
`ifdef UART_PARITY_EN
                        end else if (idx == 9) begin
                            if (uart_xmitH !== ^sh) mon_err++;
`endif
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (xmit_doneH !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check("wait_done_bound", {31'd0, xmit_doneH === 1'b1}, 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((xmit_busyH !== 1'b0 || uart_xmitH !== 1'b1) && n < limit) begin
            step();
            n++;
        end
        check("wait_idle_bound", {31'd0, xmit_busyH === 1'b0}, 32'd1);
        repeat (4) step();
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == FB - 1) return 1'b1;
        return ^d;
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        done_q.delete();
        mon_err = 0;
    endtask

    vec_t vecs[8];
    logic [7:0] exp_bytes[$];
    int   fall;
    int   zeros;

    initial begin
        vecs[0] = '{1'b1, 8'h11, 1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 8'h22, 1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h33, 2, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h44, 3, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h55, 4, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h66, 4, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h77, 4, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 4, 1'b0, 1'b0};

        sys_rst_l = 1'b0;
        wr_validH = 1'b0;
        wr_dataH  = 8'h00;
        repeat (2) step();
        check("rst_line", uart_xmitH, 1);
        check("rst_done", xmit_doneH, 0);
        check("rst_busy", xmit_busyH, 0);
        check("rst_count", fifo_countH, 0);
        check("rst_ready", wr_readyH, 1);
        sys_rst_l = 1'b1;
        repeat (3) step();

        // Single 0xA5 frame: timing, bit values, done position.
        clear_mon();
        wr_validH = 1'b1;
        wr_dataH  = 8'hA5;
        step();
        check("a5_count_after_push", fifo_countH, 1);
        check("a5_line_before_pop", uart_xmitH, 1);
        check("a5_busy", xmit_busyH, 1);
        wr_validH = 1'b0;
        step();
        check("a5_start_fall", uart_xmitH, 0);
        check("a5_count_after_pop", fifo_countH, 0);
        fall = cyc;
        for (int k = 1; k <= FB * BC + 8; k++) begin
            step();
            if (k % BC == BC / 2 && k < FB * BC)
                check($sformatf("a5_bit%0d", k / BC), uart_xmitH, frame_bit(8'hA5, k / BC));
        end
        check("a5_idle_line", uart_xmitH, 1);
        check("a5_idle_busy", xmit_busyH, 0);
        check("a5_done_count", done_q.size(), 1);
        check("a5_done_cycle", (done_q.size() > 0) ? done_q[0] - fall : -1, FB * BC - 1);
        check("a5_rx_count", rx_q.size(), 1);
        check("a5_rx_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA5);

        // Three back-to-back frames.
        clear_mon();
        wr_validH = 1'b1;
        wr_dataH = 8'h00; step();
        wr_dataH = 8'hFF; step();
        wr_dataH = 8'h3C; step();
        wr_validH = 1'b0;
        wait_idle(4 * FB * BC);
        check("b2b_done_count", done_q.size(), 3);
        if (done_q.size() == 3) begin
            check("b2b_gap1", done_q[1] - done_q[0], FB * BC);
            check("b2b_gap2", done_q[2] - done_q[1], FB * BC);
        end
        exp_bytes = '{8'h00, 8'hFF, 8'h3C};
        check("b2b_rx_count", rx_q.size(), 3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++)
            check($sformatf("b2b_rx%0d", i), rx_q[i], exp_bytes[i]);

        // Fill past depth from the vector table; extra pushes while full are dropped.
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            wr_validH = vecs[i].valid;
            wr_dataH  = vecs[i].data;
            step();
            check($sformatf("fill%0d_count", i), fifo_countH, vecs[i].exp_count);
            check($sformatf("fill%0d_ready", i), wr_readyH, vecs[i].exp_ready);
            check($sformatf("fill%0d_line", i), uart_xmitH, vecs[i].exp_line);
        end
        wait_idle(7 * FB * BC);
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        check("fill_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check($sformatf("fill_rx%0d", i), rx_q[i], exp_bytes[i]);
        check("fill_frame_err", mon_err, 0);

        // Push on the last stop cycle while the FIFO pops: count holds, order kept.
        clear_mon();
        wr_validH = 1'b1;
        wr_dataH = 8'h5A; step();
        wr_dataH = 8'hC3; step();
        wr_dataH = 8'h81; step();
        wr_validH = 1'b0;
        check("pp_count_before", fifo_countH, 2);
        wait_done(FB * BC + 20);
        wr_validH = 1'b1;
        wr_dataH  = 8'h07;
        step();
        wr_validH = 1'b0;
        check("pp_count_after", fifo_countH, 2);
        check("pp_next_start", uart_xmitH, 0);
        wait_idle(5 * FB * BC);
        exp_bytes = '{8'h5A, 8'hC3, 8'h81, 8'h07};
        check("pp_rx_count", rx_q.size(), 4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++)
            check($sformatf("pp_rx%0d", i), rx_q[i], exp_bytes[i]);
        check("pp_frame_err", mon_err, 0);

        // Asynchronous reset in the middle of a data bit with three bytes queued.
        clear_mon();
        wr_validH = 1'b1;
        wr_dataH  = 8'h00;
        repeat (4) step();
        wr_validH = 1'b0;
        check("rst_mid_count_before", fifo_countH, 3);
        repeat (51) step();
        check("rst_mid_line_before", uart_xmitH, 0);
        sys_rst_l = 1'b0;
        #1;
        check("rst_mid_line", uart_xmitH, 1);
        check("rst_mid_count", fifo_countH, 0);
        check("rst_mid_ready", wr_readyH, 1);
        check("rst_mid_busy", xmit_busyH, 0);
        repeat (2) step();
        sys_rst_l = 1'b1;
        zeros = 0;
        for (int k = 0; k < 3 * BC; k++) begin
            step();
            if (uart_xmitH !== 1'b1) zeros++;
        end
        check("rst_after_line_low_cycles", zeros, 0);
        check("rst_after_count", fifo_countH, 0);
        check("rst_after_rx", rx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_xmit_fifo.md
Name: uart_xmit_fifo

Overview:
- Buffered 8N1 UART transmitter; the transmit-side counterpart of the u_rec receiver.
- Host pushes bytes with a valid/ready handshake into an internal FIFO. The block serializes them LSB-first on uart_xmitH.
- Bit timing: BIT_CELL clocks per bit, so a u_rec instance on the same sys_clk receives every frame correctly.
- Frames go out back-to-back with no idle gap while the FIFO is non-empty.

Parameters:
- BIT_CELL, 16, sys_clk cycles per bit cell; legal range 4..256.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- FIFO_AW, 2, log2(FIFO_DEPTH); pointer width.

Ports:
- sys_clk  input  1  system clock; all state changes on its rising edge.
- sys_rst_l  input  1  asynchronous active-low reset.
- wr_validH  input  1  host has a byte on wr_dataH.
- wr_dataH  input  8  byte to transmit.
- wr_readyH  output  1  FIFO can accept a byte (not full).
- uart_xmitH  output  1  serial line, idle high, registered.
- xmit_busyH  output  1  frame in progress or FIFO non-empty.
- xmit_doneH  output  1  one-cycle pulse at end of each stop bit.
- fifo_countH  output  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, immediate, also mid-frame): uart_xmitH=1, xmit_doneH=0, xmit_busyH=0, fifo_countH=0, wr_readyH=1. FIFO pointers cleared; state=IDLE; any partial frame is abandoned.
- Push: occurs on a clock edge with wr_validH=1 and wr_readyH=1. wr_readyH = (fifo_countH != FIFO_DEPTH), combinational from count only.
- Push while full: ignored, data dropped, no state change.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, PARITY (see UART_PARITY_EN), STOP.
- bit_cnt: 0..BIT_CELL-1, cleared on every state or bit change. bit_idx: 0..7.
- IDLE: uart_xmitH=1.
  - If count>0 at an edge: pop head into shift register, state<=START, uart_xmitH<=0 on that same edge.
  - Pop latency: a byte pushed into an empty FIFO at edge N is popped at edge N+1, so the start bit begins at N+1.
- START: hold 0 for BIT_CELL cycles, then state<=DATA with bit_idx=0 and uart_xmitH<=shift[0].
- DATA: each bit is held exactly BIT_CELL cycles, then the register shifts right.
  - After bit_idx=7 completes: go to STOP with uart_xmitH<=1 (PARITY first if enabled).
- STOP: hold 1 for BIT_CELL cycles.
  - On the last stop cycle: xmit_doneH pulses high for exactly one cycle.
  - If count>0 at that edge: pop and go directly to START (line drops to 0 on the next cycle, no gap).
  - Otherwise: go to IDLE.
- Frame length: exactly 10*BIT_CELL cycles (11*BIT_CELL with parity). Start-bit falling edge to done pulse = 10*BIT_CELL-1 cycles.
- xmit_busyH = (state!=IDLE) || (count!=0); registered or combinational, but glitch-free at edges.
- Pushes during transmission are accepted normally. The FIFO head is never overwritten; the active frame uses the shift-register copy.
- Illegal state encoding: recover to IDLE with uart_xmitH=1 on the next edge. No X propagation.

Optional Feature:
- Macro: UART_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP, lasting BIT_CELL cycles.
  - Line value is even parity: the XOR of the 8 data bits.
  - Frame is 11*BIT_CELL cycles.
- When undefined: no PARITY state or logic; 8N1 framing as above.

Test Plan:
- Reset, then a single push of 0xA5 with BIT_CELL=16 -> line falls one cycle after the push; sampled mid-cell it reads 0,1,0,1,0,0,1,0,1,1; xmit_doneH pulses at cycle 159 after the falling edge; then idle high.
- Push 0x00, 0xFF, 0x3C on consecutive cycles -> three frames with no idle gap; stop bit of each is immediately followed by a start bit; three done pulses spaced 160 cycles apart.
- Push 5 bytes on consecutive cycles with FIFO_DEPTH=4 -> wr_readyH drops when count reaches 4. Per the pop latency, the first byte is popped one cycle after its push, so all 5 are accepted with no drop; fifo_countH peaks at 4. Hold wr_validH while full -> extra byte is dropped, count stays 4.
- Push while a pop occurs (count=2, push on the last stop cycle) -> count remains 2, data order preserved.
- Assert sys_rst_l=0 mid-data-bit with count=3 -> uart_xmitH=1 and count=0 immediately, asynchronously; after release, line stays idle.
- With UART_PARITY_EN, push 0x07 -> parity bit = 1; frame is 176 cycles. Loopback into u_rec (BIT_CELL=16, undefined macro) receives 0xA5 correctly.
